trap_csr_unit: RTL and testbench

//  Responder for the PCU's trap handshake. Accepts a trap request (cause, faulting PC, info word) and runs the CSR update:

---
 rtl/trap_csr_unit_pkg.sv | 56 +++++
 rtl/trap_csr_unit_if.sv | 31 +++
 rtl/trap_csr_unit_regs.sv | 86 ++++++++
 rtl/trap_csr_unit.sv | 117 +++++++++++
 tb/tb_trap_csr_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_csr_unit_pkg.sv
// Shared definitions for the trap/CSR responder: PCU cause codes, CSR
// addresses, mcause encodings and the sequencer state encoding.
package trap_csr_unit_pkg;

    // Cause codes as driven by the PCU
    typedef enum logic [3:0] {
        No_Error        = 4'd0,
        Is_Breakpoint   = 4'd1,
        Is_Div_By_Zero  = 4'd2,
        Is_Mem_Access   = 4'd3,
        Is_Decode_Error = 4'd4
    } trap_cause_e;

    // M-mode trap CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // mstatus bit positions; all other mstatus bits read as zero
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // mcause values reported to software for each PCU cause
    localparam logic [31:0] MCAUSE_BREAKPOINT  = 32'd3;
    localparam logic [31:0] MCAUSE_DIV_BY_ZERO = 32'h18;
    localparam logic [31:0] MCAUSE_MEM_ACCESS  = 32'd5;
    localparam logic [31:0] MCAUSE_DECODE      = 32'd2;

    // Trap sequencer states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SET_MTVAL  = 3'd1,
        ST_SET_MEPC   = 3'd2,
        ST_SET_MCAUSE = 3'd3,
        ST_REDIRECT   = 3'd4,
        ST_IN_HANDLER = 3'd5,
        ST_RETURN     = 3'd6
    } state_e;

    // Translate a PCU cause code into the architectural mcause value
    function automatic logic [31:0] map_cause(input logic [3:0] cause);
        logic [31:0] code;
        code = 32'd0;
        case (cause)
            Is_Breakpoint:   code = MCAUSE_BREAKPOINT;
            Is_Div_By_Zero:  code = MCAUSE_DIV_BY_ZERO;
            Is_Mem_Access:   code = MCAUSE_MEM_ACCESS;
            Is_Decode_Error: code = MCAUSE_DECODE;
            default:         code = 32'd0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/trap_csr_unit_if.sv
// Trap/mret handshake, fetch redirect and CSR software port between the
// PCU side (master) and the trap/CSR responder (slave).
interface trap_csr_unit_if;
    logic        trap_req;
    logic [3:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_info;
    logic        trap_ack;
    logic        mret_req;
    logic        mret_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;

    modport master (
        output trap_req, trap_cause, trap_pc, trap_info, mret_req,
               csr_raddr, csr_wen, csr_waddr, csr_wdata,
        input  trap_ack, mret_ack, redirect_valid, redirect_pc, busy, csr_rdata
    );

    modport slave (
        input  trap_req, trap_cause, trap_pc, trap_info, mret_req,
               csr_raddr, csr_wen, csr_waddr, csr_wdata,
        output trap_ack, mret_ack, redirect_valid, redirect_pc, busy, csr_rdata
    );
endinterface

// File: rtl/trap_csr_unit_regs.sv
// M-mode trap CSRs. Software write port merged with the trap sequencer's
// write strobes; the sequencer has priority on any CSR it touches.
module trap_csr_unit_regs
    import trap_csr_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_1000,
    parameter logic        MIE_RESET   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    input  logic        csr_wen,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic        seq_mtval_we,
    input  logic [31:0] seq_mtval,
    input  logic        seq_mepc_we,
    input  logic [31:0] seq_mepc,
    input  logic        seq_trap_we,
    input  logic [31:0] seq_mcause,
    input  logic        seq_mret_we,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic        mie
);

    logic [31:0] mtval;
    logic [31:0] mcause;
    logic        mpie;

    // CSR state: software writes first, sequencer writes afterwards so
    // the later non-blocking assignment wins on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec  <= MTVEC_RESET & ~32'h3;
            mepc   <= 32'd0;
            mtval  <= 32'd0;
            mcause <= 32'd0;
            mie    <= MIE_RESET;
            mpie   <= 1'b0;
        end else begin
            if (csr_wen) begin
                case (csr_waddr)
                    CSR_MSTATUS: begin
                        mie  <= csr_wdata[MSTATUS_MIE];
                        mpie <= csr_wdata[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:  mtvec  <= csr_wdata & ~32'h3;
                    CSR_MEPC:   mepc   <= csr_wdata & ~32'h3;
                    CSR_MCAUSE: mcause <= csr_wdata;
                    CSR_MTVAL:  mtval  <= csr_wdata;
                    default: ;
                endcase
            end
            if (seq_mtval_we) mtval <= seq_mtval;
            if (seq_mepc_we)  mepc  <= seq_mepc & ~32'h3;
            if (seq_trap_we) begin
                mcause <= seq_mcause;
                mpie   <= mie;
                mie    <= 1'b0;
            end
            if (seq_mret_we) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
        end
    end

    // Combinational software read mux; unmapped addresses read zero
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_raddr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]  = mie;
                csr_rdata[MSTATUS_MPIE] = mpie;
            end
            CSR_MTVEC:  csr_rdata = mtvec;
            CSR_MEPC:   csr_rdata = mepc;
            CSR_MCAUSE: csr_rdata = mcause;
            CSR_MTVAL:  csr_rdata = mtval;
            default:    csr_rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/trap_csr_unit.sv
// Trap responder: accepts a PCU trap, sequences mtval -> mepc ->
// mcause/mstatus, redirects fetch to mtvec, and handles mret back to mepc.
module trap_csr_unit
    import trap_csr_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_1000,
    parameter logic        MIE_RESET   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    trap_csr_unit_if.slave   bus
);

    state_e      state;
    logic [3:0]  cause_q;
    logic [31:0] pc_q;
    logic [31:0] info_q;
    logic        trap_ack_q;
    logic        mret_ack_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie;
    logic        seq_mtval_we;
    logic        seq_mepc_we;
    logic        seq_trap_we;
    logic        seq_mret_we;
    logic [31:0] seq_mcause;

    // Sequencer CSR write strobes decode directly from the current state
    always_comb begin
        seq_mtval_we = (state == ST_SET_MTVAL);
        seq_mepc_we  = (state == ST_SET_MEPC);
        seq_trap_we  = (state == ST_SET_MCAUSE);
        seq_mret_we  = (state == ST_RETURN);
        seq_mcause   = map_cause(cause_q);
    end

    trap_csr_unit_regs #(
        .MTVEC_RESET (MTVEC_RESET),
        .MIE_RESET   (MIE_RESET)
    ) u_regs (
        .clk          (clk),
        .rst          (rst),
        .csr_raddr    (bus.csr_raddr),
        .csr_rdata    (bus.csr_rdata),
        .csr_wen      (bus.csr_wen),
        .csr_waddr    (bus.csr_waddr),
        .csr_wdata    (bus.csr_wdata),
        .seq_mtval_we (seq_mtval_we),
        .seq_mtval    (info_q),
        .seq_mepc_we  (seq_mepc_we),
        .seq_mepc     (pc_q),
        .seq_trap_we  (seq_trap_we),
        .seq_mcause   (seq_mcause),
        .seq_mret_we  (seq_mret_we),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .mie          (mie)
    );

    // Trap/mret FSM with input latches and registered one-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            cause_q          <= 4'd0;
            pc_q             <= 32'd0;
            info_q           <= 32'd0;
            trap_ack_q       <= 1'b0;
            mret_ack_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            trap_ack_q       <= 1'b0;
            mret_ack_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Masked or cause-less requests stay pending; mret is ignored here
                    if (bus.trap_req && (bus.trap_cause != No_Error) && mie) begin
                        cause_q <= bus.trap_cause;
                        pc_q    <= bus.trap_pc;
                        info_q  <= bus.trap_info;
                        state   <= ST_SET_MTVAL;
                    end
                end
                ST_SET_MTVAL:  state <= ST_SET_MEPC;
                ST_SET_MEPC:   state <= ST_SET_MCAUSE;
                ST_SET_MCAUSE: state <= ST_REDIRECT;
                ST_REDIRECT: begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= mtvec;
                    trap_ack_q       <= 1'b1;
                    state            <= ST_IN_HANDLER;
                end
                ST_IN_HANDLER: begin
                    if (bus.mret_req) state <= ST_RETURN;
                end
                ST_RETURN: begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= mepc;
                    mret_ack_q       <= 1'b1;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.trap_ack       = trap_ack_q;
    assign bus.mret_ack       = mret_ack_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.busy           = (state != ST_IDLE) && (state != ST_IN_HANDLER);

endmodule

// File: tb/tb_trap_csr_unit.sv
// Bench for trap_csr_unit: CSR map vector table, scoreboarded redirect
// pulses with cycle-exact latency, and hand-written trap/mret/reset sequences.
module tb_trap_csr_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_trap_ack = 0;
    int   n_mret_ack = 0;
    logic prev_rv = 1'b0;

    trap_csr_unit_if bus ();

    trap_csr_unit #(
        .MTVEC_RESET (32'h0000_1000),
        .MIE_RESET   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_mret;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    typedef struct {
        logic        wen;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = addr;
        bus.csr_wdata = data;
        tick();
        bus.csr_wen   = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] addr, input logic [31:0] expv, input string name);
        bus.csr_raddr = addr;
        #1;
        check(name, bus.csr_rdata, expv);
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d redirects outstanding, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Pulse-rule monitor and scoreboard consumer, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ((bus.trap_ack && bus.mret_ack) ||
                ((bus.trap_ack || bus.mret_ack) !== bus.redirect_valid) ||
                (prev_rv && bus.redirect_valid)) begin
                bad++;
                $display("FAIL pulse_rules: tack=%b mack=%b rv=%b prev_rv=%b", bus.trap_ack,
                         bus.mret_ack, bus.redirect_valid, prev_rv);
            end
            if (bus.trap_ack) n_trap_ack++;
            if (bus.mret_ack) n_mret_ack++;
            if (bus.redirect_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_redirect: pc=%h cyc=%0d want none", bus.redirect_pc, cyc);
                end else begin
                    e = sb.pop_front();
                    check("redirect_kind", {31'd0, bus.mret_ack}, {31'd0, e.is_mret});
                    check("redirect_pc", bus.redirect_pc, e.pc);
                    check("redirect_cycle", cyc, e.cyc);
                    check("busy_at_redirect", {31'd0, bus.busy}, 32'd0);
                end
            end
            prev_rv = bus.redirect_valid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0;
        int mrets0;

        vt[0]  = '{1'b0, 12'h000, 32'h0,         12'h305, 32'h0000_1000, "rst_mtvec"};
        vt[1]  = '{1'b0, 12'h000, 32'h0,         12'h300, 32'h0000_0008, "rst_mstatus"};
        vt[2]  = '{1'b0, 12'h000, 32'h0,         12'h341, 32'h0,         "rst_mepc"};
        vt[3]  = '{1'b0, 12'h000, 32'h0,         12'h342, 32'h0,         "rst_mcause"};
        vt[4]  = '{1'b0, 12'h000, 32'h0,         12'h343, 32'h0,         "rst_mtval"};
        vt[5]  = '{1'b0, 12'h000, 32'h0,         12'h123, 32'h0,         "unmapped_rd"};
        vt[6]  = '{1'b1, 12'h305, 32'h0000_3003, 12'h305, 32'h0000_3000, "mtvec_align"};
        vt[7]  = '{1'b1, 12'h341, 32'h0000_2007, 12'h341, 32'h0000_2004, "mepc_align"};
        vt[8]  = '{1'b1, 12'h342, 32'hDEAD_BEEF, 12'h342, 32'hDEAD_BEEF, "mcause_wr"};
        vt[9]  = '{1'b1, 12'h343, 32'h1234_5678, 12'h343, 32'h1234_5678, "mtval_wr"};
        vt[10] = '{1'b1, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_0088, "mstatus_mask"};
        vt[11] = '{1'b1, 12'h300, 32'h0,         12'h300, 32'h0,         "mstatus_clr"};
        vt[12] = '{1'b1, 12'h300, 32'h0000_0008, 12'h300, 32'h0000_0008, "mstatus_mie"};
        vt[13] = '{1'b1, 12'h344, 32'h0000_FFFF, 12'h344, 32'h0,         "unmapped_wr"};
        vt[14] = '{1'b1, 12'h305, 32'h0000_1000, 12'h305, 32'h0000_1000, "mtvec_restore"};

        bus.trap_req = 1'b0; bus.trap_cause = 4'd0; bus.trap_pc = 32'd0; bus.trap_info = 32'd0;
        bus.mret_req = 1'b0; bus.csr_raddr = 12'd0; bus.csr_wen = 1'b0;
        bus.csr_waddr = 12'd0; bus.csr_wdata = 32'd0;

        // Reset state of the pulse and redirect outputs
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("rst_acks", {30'd0, bus.trap_ack, bus.mret_ack}, 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'd0);

        // CSR map table
        for (int i = 0; i < 15; i++) begin
            bus.csr_wen   = vt[i].wen;
            bus.csr_waddr = vt[i].waddr;
            bus.csr_wdata = vt[i].wdata;
            bus.csr_raddr = vt[i].raddr;
            tick();
            bus.csr_wen = 1'b0;
            #1;
            check(vt[i].name, bus.csr_rdata, vt[i].exp);
        end

        // Breakpoint trap: redirect to mtvec four cycles after acceptance
        tick();
        bus.trap_req = 1'b1; bus.trap_cause = 4'd1; bus.trap_pc = 32'h2004; bus.trap_info = 32'h2004;
        sb.push_back('{1'b0, 32'h1000, cyc + 5});
        wait_drain(20, "trap_bp");
        bus.trap_req = 1'b0;
        csr_rd(12'h341, 32'h2004, "bp_mepc");
        csr_rd(12'h342, 32'h3,    "bp_mcause");
        csr_rd(12'h343, 32'h2004, "bp_mtval");
        csr_rd(12'h300, 32'h80,   "bp_mstatus");

        // mret: redirect to mepc the cycle after it is sampled; MPIE is set on return
        tick();
        bus.mret_req = 1'b1;
        sb.push_back('{1'b1, 32'h2004, cyc + 2});
        wait_drain(20, "mret_bp");
        bus.mret_req = 1'b0;
        check("mret_busy", {31'd0, bus.busy}, 32'd0);
        csr_rd(12'h300, 32'h88, "mret_mstatus");

        // Masked trap stays pending until software sets MIE
        tick();
        csr_wr(12'h300, 32'h0);
        bus.trap_req = 1'b1; bus.trap_cause = 4'd3; bus.trap_pc = 32'h5008; bus.trap_info = 32'h0ABC;
        acks0 = n_trap_ack;
        repeat (10) tick();
        check("masked_no_ack", acks0, n_trap_ack);
        check("masked_busy", {31'd0, bus.busy}, 32'd0);
        sb.push_back('{1'b0, 32'h1000, cyc + 6});
        csr_wr(12'h300, 32'h8);
        wait_drain(20, "trap_unmask");
        bus.trap_req = 1'b0;
        csr_rd(12'h342, 32'h5,    "mem_mcause");
        csr_rd(12'h341, 32'h5008, "mem_mepc");
        csr_rd(12'h343, 32'h0ABC, "mem_mtval");
        tick();
        bus.mret_req = 1'b1;
        sb.push_back('{1'b1, 32'h5008, cyc + 2});
        wait_drain(20, "mret_mem");
        bus.mret_req = 1'b0;

        // cause=0 is never accepted
        tick();
        bus.trap_req = 1'b1; bus.trap_cause = 4'd0;
        acks0 = n_trap_ack;
        repeat (6) tick();
        check("cause0_no_ack", acks0, n_trap_ack);
        check("cause0_busy", {31'd0, bus.busy}, 32'd0);
        bus.trap_req = 1'b0;

        // Relocated mtvec and decode-error trap
        tick();
        csr_wr(12'h305, 32'h3003);
        csr_rd(12'h305, 32'h3000, "mtvec_reloc");
        tick();
        bus.trap_req = 1'b1; bus.trap_cause = 4'd4; bus.trap_pc = 32'h7000; bus.trap_info = 32'hFFFF_FFFF;
        sb.push_back('{1'b0, 32'h3000, cyc + 5});
        wait_drain(20, "trap_decode");
        bus.trap_req = 1'b0;
        csr_rd(12'h342, 32'h2,         "dec_mcause");
        csr_rd(12'h343, 32'hFFFF_FFFF, "dec_mtval");
        csr_rd(12'h341, 32'h7000,      "dec_mepc");
        tick();
        bus.mret_req = 1'b1;
        sb.push_back('{1'b1, 32'h7000, cyc + 2});
        wait_drain(20, "mret_decode");
        bus.mret_req = 1'b0;

        // Inputs change and request drops after acceptance: latched values hold
        tick();
        bus.trap_req = 1'b1; bus.trap_cause = 4'd2; bus.trap_pc = 32'h8003; bus.trap_info = 32'h11;
        sb.push_back('{1'b0, 32'h3000, cyc + 5});
        tick();
        bus.trap_cause = 4'd1; bus.trap_pc = 32'hDEAD_0000; bus.trap_info = 32'h22;
        tick();
        bus.trap_req = 1'b0;
        wait_drain(20, "trap_latched");
        csr_rd(12'h342, 32'h18,   "div_mcause");
        csr_rd(12'h341, 32'h8000, "div_mepc");
        csr_rd(12'h343, 32'h11,   "div_mtval");
        tick();
        bus.mret_req = 1'b1;
        sb.push_back('{1'b1, 32'h8000, cyc + 2});
        wait_drain(20, "mret_div");
        bus.mret_req = 1'b0;

        // Reset in SET_MEPC aborts the sequence and restores reset CSRs
        tick();
        bus.trap_req = 1'b1; bus.trap_cause = 4'd1; bus.trap_pc = 32'h9000; bus.trap_info = 32'h55;
        tick();
        tick();
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        bus.trap_req = 1'b0;
        tick();
        rst = 1'b0;
        acks0 = n_trap_ack;
        check("rst2_busy", {31'd0, bus.busy}, 32'd0);
        check("rst2_redirect_pc", bus.redirect_pc, 32'd0);
        csr_rd(12'h341, 32'h0,    "rst2_mepc");
        csr_rd(12'h343, 32'h0,    "rst2_mtval");
        csr_rd(12'h342, 32'h0,    "rst2_mcause");
        csr_rd(12'h305, 32'h1000, "rst2_mtvec");
        csr_rd(12'h300, 32'h8,    "rst2_mstatus");

        // mret in IDLE is never acknowledged
        tick();
        bus.mret_req = 1'b1;
        mrets0 = n_mret_ack;
        repeat (6) tick();
        check("idle_mret_no_ack", mrets0, n_mret_ack);
        check("rst2_no_trap_ack", acks0, n_trap_ack);
        bus.mret_req = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
